// File: rtl/uart_alu_interface.sv
// uart_alu_interface
//   Command sequencer between a uart and a combinational ALU. Pops three bytes
//   from the uart RX FIFO (operand A, operand B, opcode), holds them on
//   registered ALU inputs, captures the ALU result and pushes it into the uart
//   TX FIFO.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset (0 = in reset)
//   rx_empty   RX FIFO empty
//   r_data     RX FIFO head word (show-ahead, valid while rx_empty = 0)
//   rd_uart    RX pop strobe
//   tx_full    TX FIFO full
//   wr_uart    TX push strobe
//   w_data     result byte to the TX FIFO
//   alu_a      registered operand A
//   alu_b      registered operand B
//   alu_op     registered opcode
//   alu_res    ALU result (combinational in alu_a/alu_b/alu_op)
//   op_err     one-cycle pulse after an illegal opcode was popped
//   busy       high while a command is in progress (any state but S_A)
//   state_dbg  current FSM state, for debug and checkers
//
// Handshakes: both FIFO strobes are valid/ready style. A pop happens on the
// rising edge where rd_uart = 1, and rd_uart is only raised while rx_empty = 0.
// A push happens on the rising edge where wr_uart = 1, and wr_uart is only
// raised while tx_full = 0. Each strobe is a single-cycle transfer.

module uart_alu_interface #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [DBIT-1:0]  r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [DBIT-1:0]  w_data,
  output logic [DBIT-1:0]  alu_a,
  output logic [DBIT-1:0]  alu_b,
  output logic [NB_OP-1:0] alu_op,
  input  logic [DBIT-1:0]  alu_res,
  output logic             op_err,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_SEND = 3'd4
  } state_t;

  state_t state, state_next;

  logic [NB_OP-1:0] op_in;
  logic             op_legal;

  assign op_in = r_data[NB_OP-1:0];

  always_comb begin
    op_legal = 1'b0;
    case (op_in)
      NB_OP'(6'h20), NB_OP'(6'h22), NB_OP'(6'h24), NB_OP'(6'h25),
      NB_OP'(6'h26), NB_OP'(6'h27), NB_OP'(6'h03), NB_OP'(6'h02):
        op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_A;
    else        state <= state_next;
  end

  // Next state and strobes. The strobes are also forced low while reset is
  // asserted so the FIFOs never see a transfer during reset.
  always_comb begin
    state_next = state;
    rd_uart    = 1'b0;
    wr_uart    = 1'b0;
    busy       = 1'b0;
    case (state)
      S_A: begin
        rd_uart = !rx_empty;
        if (!rx_empty) state_next = S_B;
      end
      S_B: begin
        busy    = 1'b1;
        rd_uart = !rx_empty;
        if (!rx_empty) state_next = S_OP;
      end
      S_OP: begin
        busy    = 1'b1;
        rd_uart = !rx_empty;
        if (!rx_empty) state_next = op_legal ? S_CALC : S_A;
      end
      S_CALC: begin
        busy       = 1'b1;
        state_next = S_SEND;
      end
      S_SEND: begin
        busy    = 1'b1;
        wr_uart = !tx_full;
        if (!tx_full) state_next = S_A;
      end
      default: state_next = S_A;
    endcase
    if (!reset) begin
      rd_uart = 1'b0;
      wr_uart = 1'b0;
      busy    = 1'b0;
    end
  end

  // Datapath registers. An illegal opcode is not loaded into alu_op so the
  // ALU keeps seeing the previous command's opcode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      w_data <= '0;
      op_err <= 1'b0;
    end else begin
      op_err <= 1'b0;
      case (state)
        S_A:    if (!rx_empty) alu_a <= r_data;
        S_B:    if (!rx_empty) alu_b <= r_data;
        S_OP: begin
          if (!rx_empty) begin
            if (op_legal) alu_op <= op_in;
            else          op_err <= 1'b1;
          end
        end
        // ALU inputs have been stable for this whole cycle.
        S_CALC: w_data <= alu_res;
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb_uart_alu_interface
//   Bench for uart_alu_interface. Models the RX FIFO as a byte array with
//   read/write pointers, models the ALU, and checks every TX push against a
//   queue of expected result bytes.

module tb_uart_alu_interface;

  localparam int DBIT  = 8;
  localparam int NB_OP = 6;

  localparam logic [2:0] ST_A    = 3'd0;
  localparam logic [2:0] ST_B    = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             rx_empty;
  logic [DBIT-1:0]  r_data;
  logic             rd_uart;
  logic             tx_full = 1'b0;
  logic             wr_uart;
  logic [DBIT-1:0]  w_data;
  logic [DBIT-1:0]  alu_a;
  logic [DBIT-1:0]  alu_b;
  logic [NB_OP-1:0] alu_op;
  logic [DBIT-1:0]  alu_res;
  logic             op_err;
  logic             busy;
  logic [2:0]       state_dbg;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  logic [DBIT-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  uart_alu_interface #(.DBIT(DBIT), .NB_OP(NB_OP)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .op_err(op_err), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- RX FIFO model ----------------
  logic [7:0] rx_mem [0:255];
  logic [7:0] rx_wr = 8'd0;
  logic [7:0] rx_rd = 8'd0;

  assign rx_empty = (rx_wr == rx_rd);
  assign r_data   = rx_mem[rx_rd];

  always @(posedge clk) begin
    if (rd_uart) begin
      if (rx_empty) begin
        errors++;
        $display("FAIL pop_on_empty: rd_uart=1 rx_empty=1 required no pop");
      end else begin
        rx_rd <= rx_rd + 8'd1;
      end
    end
  end

  // ---------------- ALU model ----------------
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      6'h20: alu_model = a + b;
      6'h22: alu_model = a - b;
      6'h24: alu_model = a & b;
      6'h25: alu_model = a | b;
      6'h26: alu_model = a ^ b;
      6'h27: alu_model = ~(a | b);
      6'h03: alu_model = 8'($signed(a) >>> b);
      6'h02: alu_model = a >> b;
      default: alu_model = 8'h00;
    endcase
  endfunction

  function automatic bit is_legal(input logic [7:0] op_byte);
    case (op_byte[5:0])
      6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  always_comb alu_res = alu_model(alu_a, alu_b, alu_op);

  // ---------------- TX scoreboard ----------------
  always @(negedge clk) begin
    if (wr_uart) begin
      wr_count++;
      checks++;
      if (tx_full) begin
        errors++;
        $display("FAIL push_on_full: wr_uart=1 with tx_full=1");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_push: w_data=%02h, no result expected", w_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (w_data !== e) begin
          errors++;
          $display("FAIL tx_data: got %02h expected %02h", w_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_mem[rx_wr] = b;
    rx_wr = rx_wr + 8'd1;
  endtask

  // Push a whole command; queue its result when the opcode is legal.
  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    if (is_legal(op)) exp_q.push_back(alu_model(a, b, op[5:0]));
    push_byte(a);
    push_byte(b);
    push_byte(op);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !rx_empty || state_dbg !== ST_A) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: pending=%0d state=%0d after %0d cycles, required idle",
               name, exp_q.size(), state_dbg, budget);
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  // Reset held with a full ADD command waiting in the RX FIFO; nothing may move.
  task automatic test_reset();
    int bad = 0;
    reset = 1'b0;
    send_cmd(8'h05, 8'h03, 8'h20);
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rd_uart !== 1'b0 || wr_uart !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_strobes: rd=%b wr=%b busy=%b required 0", rd_uart, wr_uart, busy);
    end
    checks++;
    if ({alu_a, alu_b, alu_op, w_data, op_err} !== '0 || state_dbg !== ST_A) begin
      errors++;
      $display("FAIL reset_values: a=%02h b=%02h op=%02h w=%02h err=%b st=%0d required 0",
               alu_a, alu_b, alu_op, w_data, op_err, state_dbg);
    end
    checks++;
    if (rx_rd !== 8'd0) begin
      errors++;
      $display("FAIL reset_no_pop: rx_rd=%0d required 0", rx_rd);
    end
    reset = 1'b1;
  endtask

  task automatic test_add();
    wait_done("add", 30);
    checks++;
    if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_op !== 6'h20 || w_data !== 8'h08) begin
      errors++;
      $display("FAIL add_regs: a=%02h b=%02h op=%02h w=%02h required 05 03 20 08",
               alu_a, alu_b, alu_op, w_data);
    end
  endtask

  task automatic test_sub();
    int wr_before = wr_count;
    send_cmd(8'h03, 8'h05, 8'h22);
    wait_done("sub", 30);
    checks++;
    if (w_data !== 8'hFE || wr_count != wr_before + 1) begin
      errors++;
      $display("FAIL sub_result: w=%02h pushes=%0d required FE and 1", w_data,
               wr_count - wr_before);
    end
  endtask

  task automatic test_illegal();
    int wr_before = wr_count;
    int err_cycles = 0;
    push_byte(8'h0F);
    push_byte(8'h01);
    push_byte(8'h3F);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (op_err === 1'b1) err_cycles++;
    end
    checks++;
    if (err_cycles != 1) begin
      errors++;
      $display("FAIL illegal_op_err: high %0d cycles required 1", err_cycles);
    end
    checks++;
    if (wr_count != wr_before || state_dbg !== ST_A) begin
      errors++;
      $display("FAIL illegal_no_push: pushes=%0d state=%0d required 0 and 0",
               wr_count - wr_before, state_dbg);
    end
    checks++;
    if (alu_op !== 6'h22) begin
      errors++;
      $display("FAIL illegal_keep_op: alu_op=%02h required 22", alu_op);
    end
    push_byte(8'hAA);
    tick();
    tick();
    checks++;
    if (alu_a !== 8'hAA || state_dbg !== ST_B) begin
      errors++;
      $display("FAIL illegal_next_a: alu_a=%02h state=%0d required AA and 1", alu_a, state_dbg);
    end
    exp_q.push_back(alu_model(8'hAA, 8'h01, 6'h20));
    push_byte(8'h01);
    push_byte(8'h20);
    wait_done("illegal_recover", 30);
  endtask

  task automatic test_tx_full();
    int wr_before = wr_count;
    int n = 0;
    int bad = 0;
    logic [7:0] hold;
    tx_full = 1'b1;
    send_cmd(8'h10, 8'h21, 8'h25);
    while (state_dbg !== ST_SEND && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL txfull_reach_send: state=%0d required 4", state_dbg);
    end
    hold = w_data;
    checks++;
    if (hold !== 8'h31) begin
      errors++;
      $display("FAIL txfull_data: w=%02h required 31", hold);
    end
    // A byte arriving while a result is pending must stay in the RX FIFO.
    push_byte(8'h55);
    #1;
    for (int i = 0; i < 10; i++) begin
      if (wr_uart !== 1'b0 || rd_uart !== 1'b0 || w_data !== hold) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || rx_empty) begin
      errors++;
      $display("FAIL txfull_hold: bad_cycles=%0d rx_empty=%b required 0 and 0", bad, rx_empty);
    end
    exp_q.push_back(alu_model(8'h55, 8'h01, 6'h27));
    push_byte(8'h01);
    push_byte(8'h27);
    tx_full = 1'b0;
    wait_done("txfull", 40);
    checks++;
    if (wr_count != wr_before + 2 || w_data !== 8'hAA) begin
      errors++;
      $display("FAIL txfull_release: pushes=%0d w=%02h required 2 and AA",
               wr_count - wr_before, w_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] rd_hist = '0;
    int first_wr = -1;
    send_cmd(8'h07, 8'h03, 8'h22);
    #1;
    for (int i = 0; i < 10; i++) begin
      rd_hist[i] = rd_uart;
      if (wr_uart === 1'b1 && first_wr < 0) first_wr = i;
      tick();
    end
    checks++;
    if (rd_hist !== 10'b00_0000_0111) begin
      errors++;
      $display("FAIL b2b_pops: pattern=%b required 0000000111", rd_hist);
    end
    checks++;
    if (first_wr != 4) begin
      errors++;
      $display("FAIL b2b_latency: first push cycle=%0d required 4", first_wr);
    end
    wait_done("b2b", 20);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    push_byte(8'h11);
    while (state_dbg !== ST_B && n < 10) begin
      tick();
      n++;
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({alu_a, alu_b, alu_op, w_data, op_err, rd_uart, wr_uart, busy} !== '0 ||
        state_dbg !== ST_A) begin
      errors++;
      $display("FAIL midreset_values: a=%02h b=%02h op=%02h w=%02h st=%0d required all 0",
               alu_a, alu_b, alu_op, w_data, state_dbg);
    end
    tick();
    tick();
    reset = 1'b1;
    send_cmd(8'h02, 8'h02, 8'h20);
    wait_done("midreset", 30);
    checks++;
    if (w_data !== 8'h04 || alu_a !== 8'h02) begin
      errors++;
      $display("FAIL midreset_cmd: w=%02h a=%02h required 04 and 02", w_data, alu_a);
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    int wr_before = wr_count;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] a, b, op;
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      op = ops[$urandom_range(0, 7)];
      if (op == 8'h03 || op == 8'h02) b = 8'($urandom_range(0, 7));
      exp_q.push_back(alu_model(a, b, op[5:0]));
      push_byte(a);
      repeat ($urandom_range(0, 2)) tick();
      push_byte(b);
      repeat ($urandom_range(0, 2)) tick();
      push_byte(op);
      tx_full = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) tick();
      tx_full = 1'b0;
    end
    wait_done("random", 200);
    checks++;
    if (wr_count != wr_before + 12) begin
      errors++;
      $display("FAIL random_count: pushes=%0d required 12", wr_count - wr_before);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_illegal();
    test_tx_full();
    test_back_to_back();
    test_reset_mid();
    test_random();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d results never pushed, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
